// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit.
//   lsu_state_t : unit state (IDLE, ACCESS, RESP)
//   F3_*        : RV32I load/store funct3 encodings
//   ERR_*       : resp_err codes
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

endpackage

// File: rtl/load_align.sv
// Combinational load data extraction: selects the byte/halfword lane given by
// the low address bits and sign- or zero-extends it according to funct3.
//   funct3 : load funct3
//   offset : byte address bits [1:0]
//   word   : raw memory word
//   rdata  : extended 32-bit load value
module load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] rdata
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{offset, 3'b000} +: 8];
    lane_h = offset[1] ? word[31:16] : word[15:0];
    rdata  = word;
    case (funct3)
      F3_B:    rdata = {{24{lane_b[7]}}, lane_b};
      F3_H:    rdata = {{16{lane_h[15]}}, lane_h};
      F3_BU:   rdata = {24'b0, lane_b};
      F3_HU:   rdata = {16'b0, lane_h};
      default: rdata = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Handshaked RV32I load/store unit between the core and data memory.
// Generates byte enables and lane-replicated store data, extends load data,
// stalls the core while an access is outstanding, and reports misaligned,
// illegal-funct3 and timeout errors.
//   clk, rst_n                : clock, synchronous active-low reset
//   req_*                     : core request (held stable while stall=1)
//   req_ready, stall          : combinational handshake toward the core
//   resp_valid/rdata/err      : one-cycle registered completion
//   mem_req/we/addr/be/wdata  : registered memory request, held until mem_ack
//   mem_ack, mem_rdata        : memory completion and read word
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              stall,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic [1:0]        resp_err_q, resp_err_d;
  // Kept from the accepted request so extraction does not depend on req_* later.
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        offset_q, offset_d;

  logic              illegal;
  logic              misalign;
  logic [3:0]        be;
  logic [31:0]       st_data;
  logic [31:0]       ld_data;

  load_align u_load_align (
    .funct3 (funct3_q),
    .offset (offset_q),
    .word   (mem_rdata),
    .rdata  (ld_data)
  );

  // Request decode: legality, alignment, byte enables and store lanes.
  always_comb begin
    if (req_we) begin
      illegal = !(req_funct3 inside {F3_B, F3_H, F3_W});
    end else begin
      illegal = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end
    misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
               ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    be      = 4'b1111;
    st_data = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be      = 4'b0001 << req_addr[1:0];
        st_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be      = req_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{req_wdata[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        st_data = req_wdata;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    funct3_d     = funct3_q;
    offset_d     = offset_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (illegal || misalign) begin
            // Illegal funct3 wins over misalignment; no memory access issued.
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'b0;
            resp_err_d   = illegal ? ERR_ILLEGAL : ERR_MISALIGN;
          end else begin
            state_d     = ACCESS;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = req_addr[ADDR_W-1:2];
            mem_be_d    = be;
            mem_wdata_d = st_data;
            funct3_d    = req_funct3;
            offset_d    = req_addr[1:0];
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_ack) begin
          state_d      = RESP;
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = mem_we_q ? 32'b0 : ld_data;
          resp_err_d   = ERR_OK;
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          state_d      = RESP;
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = 32'b0;
          resp_err_d   = ERR_TIMEOUT;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= ERR_OK;
      funct3_q     <= '0;
      offset_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      funct3_q     <= funct3_d;
      offset_q     <= offset_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign stall      = ((state_q == IDLE) && req_valid) || (state_q == ACCESS);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a simple acking memory model.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_total = 0;
  int n_bad   = 0;

  load_store_unit #(
    .TIMEOUT_CYCLES (16),
    .ADDR_W         (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .stall      (stall),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, act as memory acking ack_dly cycles after mem_req first
  // appears (negative: never), and check the whole transaction.
  task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int ack_dly, input logic [31:0] rword,
                         input logic [29:0] exp_maddr, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                         input logic [1:0] exp_err, input int exp_lat, input int exp_mreq);
    int  mreq_n;
    int  lat;
    bit  seen;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    mem_ack    = 1'b0;
    mem_rdata  = rword;
    #1;
    check({tag, ":stall_on_req"}, stall, 1);
    check({tag, ":ready_idle"}, req_ready, 1);
    mreq_n = 0;
    lat    = 0;
    seen   = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      step();
      mem_ack = 1'b0;
      if (resp_valid) begin
        seen = 1;
        lat  = c;
        req_valid = 1'b0;
      end else begin
        check({tag, ":stall_held"}, stall, 1);
        if (mem_req) begin
          if (mreq_n == 0) begin
            check({tag, ":mem_addr"}, mem_addr, exp_maddr);
            check({tag, ":mem_be"}, mem_be, exp_be);
            check({tag, ":mem_we"}, mem_we, we);
            check({tag, ":mem_wdata"}, mem_wdata, exp_wdata);
          end
          if (ack_dly >= 0 && mreq_n == ack_dly) mem_ack = 1'b1;
          mreq_n++;
        end
      end
    end
    if (!seen) begin
      check({tag, ":resp_seen"}, 0, 1);
    end else begin
      check({tag, ":latency"}, lat, exp_lat);
      check({tag, ":rdata"}, resp_rdata, exp_rdata);
      check({tag, ":err"}, resp_err, exp_err);
      check({tag, ":mem_req_low_resp"}, mem_req, 0);
      check({tag, ":stall_resp"}, stall, 0);
      check({tag, ":ready_resp"}, req_ready, 0);
    end
    check({tag, ":mem_req_cycles"}, mreq_n, exp_mreq);
    step();
    check({tag, ":resp_one_cycle"}, resp_valid, 0);
    check({tag, ":back_idle"}, req_ready, 1);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;
    step();
    step();
    check("rst:mem_req", mem_req, 0);
    check("rst:mem_we", mem_we, 0);
    check("rst:resp_valid", resp_valid, 0);
    check("rst:resp_rdata", resp_rdata, 0);
    check("rst:resp_err", resp_err, 0);
    check("rst:mem_addr", mem_addr, 0);
    check("rst:mem_be", mem_be, 0);
    check("rst:mem_wdata", mem_wdata, 0);
    check("rst:req_ready", req_ready, 1);
    check("rst:stall", stall, 0);
    rst_n = 1'b1;
    step();

    // Memory-path loads and stores
    run_req("lw_08", 1'b0, 3'b010, 32'h8, 32'h0, 3, 32'hDEADBEEF,
            30'h2, 4'b1111, 32'h0, 32'hDEADBEEF, 2'b00, 5, 4);
    run_req("lb_05", 1'b0, 3'b000, 32'h5, 32'h0, 0, 32'h0000_8000,
            30'h1, 4'b0010, 32'h0, 32'hFFFFFF80, 2'b00, 2, 1);
    run_req("lhu_06", 1'b0, 3'b101, 32'h6, 32'h0, 1, 32'hF00D_1234,
            30'h1, 4'b1100, 32'h0, 32'h0000F00D, 2'b00, 3, 2);
    run_req("lh_02", 1'b0, 3'b001, 32'h2, 32'h0, 0, 32'h8001_0000,
            30'h0, 4'b1100, 32'h0, 32'hFFFF8001, 2'b00, 2, 1);
    run_req("lbu_07", 1'b0, 3'b100, 32'h7, 32'h0, 0, 32'h9A00_0000,
            30'h1, 4'b1000, 32'h0, 32'h0000009A, 2'b00, 2, 1);
    run_req("sb_03", 1'b1, 3'b000, 32'h3, 32'h0000_00AB, 0, 32'h1234_5678,
            30'h0, 4'b1000, 32'hABABABAB, 32'h0, 2'b00, 2, 1);
    run_req("sh_06", 1'b1, 3'b001, 32'h6, 32'h1234_BEEF, 2, 32'h1234_5678,
            30'h1, 4'b1100, 32'hBEEFBEEF, 32'h0, 2'b00, 4, 3);
    run_req("sw_0c", 1'b1, 3'b010, 32'hC, 32'hCAFE_F00D, 0, 32'h1234_5678,
            30'h3, 4'b1111, 32'hCAFEF00D, 32'h0, 2'b00, 2, 1);

    // Error paths: no memory access, response one cycle after accept
    run_req("lw_mis", 1'b0, 3'b010, 32'h2, 32'h0, 0, 32'h1111_1111,
            30'h0, 4'b0000, 32'h0, 32'h0, 2'b01, 1, 0);
    run_req("sh_mis", 1'b1, 3'b001, 32'h1, 32'h5555, 0, 32'h1111_1111,
            30'h0, 4'b0000, 32'h0, 32'h0, 2'b01, 1, 0);
    run_req("ld_f3_011", 1'b0, 3'b011, 32'h0, 32'h0, 0, 32'h1111_1111,
            30'h0, 4'b0000, 32'h0, 32'h0, 2'b11, 1, 0);
    run_req("st_f3_100", 1'b1, 3'b100, 32'h0, 32'h77, 0, 32'h1111_1111,
            30'h0, 4'b0000, 32'h0, 32'h0, 2'b11, 1, 0);

    // Timeout: no ack, mem_req held for exactly 16 cycles
    run_req("timeout", 1'b0, 3'b010, 32'h20, 32'h0, -1, 32'h2222_2222,
            30'h8, 4'b1111, 32'h0, 32'h0, 2'b10, 17, 16);

    // Reset during ACCESS abandons the access; a late ack is ignored
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    req_wdata  = 32'h0;
    mem_rdata  = 32'h3333_3333;
    step();
    check("rstmid:mem_req_up", mem_req, 1);
    rst_n     = 1'b0;
    req_valid = 1'b0;
    step();
    check("rstmid:mem_req_low", mem_req, 0);
    check("rstmid:idle", req_ready, 1);
    rst_n   = 1'b1;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("rstmid:no_resp_1", resp_valid, 0);
    check("rstmid:no_req_1", mem_req, 0);
    step();
    check("rstmid:no_resp_2", resp_valid, 0);
    check("rstmid:still_idle", req_ready, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
